alu_sequencer: RTL and testbench
================================

# alu_sequencer

Instruction sequencer that acts as the initiator on the byte ALU's opcode/data bus. It holds a small program of 12-bit instructions, issues ALU operations one per cycle, and resolves conditional branches by requesting the ALU status byte (opcode 0xF) and sampling its flags. When the program halts, it captures the final accumulator value and reports completion to the host.

## Interface
- PROG_DEPTH, 16: program entries (power of two); ADDR_W = $clog2(PROG_DEPTH)
- WDOG_LIMIT, 255: instruction budget per run (used only with ALU_SEQ_WATCHDOG_EN)
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low; clock clk
- prog_we  in  1  program write strobe; ignored while busy
- prog_addr  in  ADDR_W  program write address
- prog_data  in  12  instruction: [11:8] opcode, [7:0] operand
- start  in  1  single-cycle run request; honoured only in IDLE
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when result is valid
- abort  out  1  run ended by watchdog; held until next start
- result  out  8  captured accumulator; held until next done
- alu_opcode  out  4  registered opcode to ALU
- alu_data  out  8  registered operand to ALU
- alu_result  in  8  ALU data_out (accumulator, or status byte the cycle after opcode 0xF)

## Operation
- ALU opcodes 0x0–0x9 are issued verbatim: nop, load, add, sub, zero, one, xor, not, shl, shr.
- Status byte bits: [0] zero, [1] negative, [2] carry/borrow.
- Sequencer opcodes (never forwarded): 0xA JZ, 0xB JN, 0xC JC, 0xD JMP, 0xE HALT. Jump target = operand[ADDR_W-1:0]; upper operand bits are ignored.
- Program opcode 0xF is reserved and executes as 0x0 (nop). The sequencer alone drives 0xF, and only to read status.
- States:
  - IDLE: pc=0. On start, go to EXEC.
  - EXEC: ALU op: issue the op, pc+1 (wraps at PROG_DEPTH). JMP: pc=target, issue nop. Jcc: issue 0xF, go to ST_WAIT. HALT: issue nop, go to DRAIN.
  - ST_WAIT: issue nop, go to ST_SAMPLE.
  - ST_SAMPLE: issue nop; the selected flag of alu_result decides pc=target or pc+1; go to EXEC.
  - DRAIN: issue nop; result<=alu_result; done=1; go to IDLE.
- Program memory is not reset. The bench must write it before start.
- prog_we and start are ignored while busy. A start arriving together with prog_we in IDLE writes first; the run begins the next cycle and sees the new contents.

## Timing
- Reset values: busy=0, done=0, abort=0, result=0x00, alu_opcode=0x0, alu_data=0x00, pc=0, state IDLE.
- Reset mid-run returns to IDLE at the next edge. Outputs take their reset values; no done pulse.
- busy rises on the edge after start and falls on the edge that asserts done.
- Instruction costs: ALU op or JMP = 1 cycle; Jcc = 3 cycles (EXEC, ST_WAIT, ST_SAMPLE); HALT = 2 cycles (EXEC, DRAIN).
- The ALU applies an issued op one cycle after it is registered, so status sampled in ST_SAMPLE includes the op issued just before the branch.
- alu_data is 0x00 whenever alu_opcode is nop or 0xF.

## Configuration
- ALU_SEQ_WATCHDOG_EN defined:
  - An 8-bit counter, cleared on start, counts EXEC cycles.
  - On reaching WDOG_LIMIT, the sequencer goes to DRAIN instead of executing, with abort=1. done and result behave as for HALT.
- Not defined: no counter; abort tied 0; a program without HALT runs until reset.

## Structure
- Package alu_seq_pkg holds:
  - opcode constants for ALU ops 0x0–0x9 and 0xF and sequencer ops 0xA–0xE;
  - status bit indices (ST_ZERO=0, ST_NEG=1, ST_CARRY=2);
  - instruction width 12 and field slices;
  - the FSM state enum.
- One sub-module, alu_seq_progmem: a PROG_DEPTH×12 flop array with synchronous write port and asynchronous read port.

## Test plan
- Program {LOAD 0x05, ADD 0x03, HALT}, start → alu_opcode sequence 1, 2, 0; done 4 cycles after start; result=0x08.
- Program {0:LOAD 3, 1:SUB 1, 2:JZ 4, 3:JMP 1, 4:HALT} → exactly 3 SUB issues, 0xF issued 3 times; result=0x00.
- Program {LOAD 0xFF, ADD 0x01, JC 4, LOAD 0x55, HALT} → branch taken, LOAD 0x55 never issued; result=0x00.
- Repeat start and prog_we at addr 0 during a run → both ignored; the rerun produces an identical opcode trace.
- rst_n=0 during ST_WAIT → next cycle busy=0, alu_opcode=0x0, result=0x00; no done pulse.
- With ALU_SEQ_WATCHDOG_EN, program {0:JMP 0} → done and abort=1 after 255 EXEC cycles. Without the macro → busy stays 1 for 1000 cycles.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, status bit positions, instruction fields and FSM states
// for the ALU instruction sequencer.
package alu_seq_pkg;

    localparam int INSTR_W  = 12;
    localparam int OPC_W    = 4;
    localparam int OPND_W   = 8;
    localparam int OPC_MSB  = 11;
    localparam int OPC_LSB  = 8;
    localparam int OPND_MSB = 7;
    localparam int OPND_LSB = 0;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_NOP    = 4'h0;
    localparam opcode_t OP_LOAD   = 4'h1;
    localparam opcode_t OP_ADD    = 4'h2;
    localparam opcode_t OP_SUB    = 4'h3;
    localparam opcode_t OP_ZERO   = 4'h4;
    localparam opcode_t OP_ONE    = 4'h5;
    localparam opcode_t OP_XOR    = 4'h6;
    localparam opcode_t OP_NOT    = 4'h7;
    localparam opcode_t OP_SHL    = 4'h8;
    localparam opcode_t OP_SHR    = 4'h9;
    localparam opcode_t OP_JZ     = 4'hA;
    localparam opcode_t OP_JN     = 4'hB;
    localparam opcode_t OP_JC     = 4'hC;
    localparam opcode_t OP_JMP    = 4'hD;
    localparam opcode_t OP_HALT   = 4'hE;
    localparam opcode_t OP_STATUS = 4'hF;

    localparam int ST_ZERO  = 0;
    localparam int ST_NEG   = 1;
    localparam int ST_CARRY = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_ST_WAIT,
        S_ST_SAMPLE,
        S_DRAIN
    } seq_state_t;

    function automatic opcode_t instr_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [OPND_W-1:0] instr_operand(input logic [INSTR_W-1:0] instr);
        return instr[OPND_MSB:OPND_LSB];
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Opcode/data bus between the sequencer (initiator) and the byte ALU.
interface alu_sequencer_if;
    logic [3:0] alu_opcode;
    logic [7:0] alu_data;
    logic [7:0] alu_result;

    modport master (
        output alu_opcode,
        output alu_data,
        input  alu_result
    );

    modport slave (
        input  alu_opcode,
        input  alu_data,
        output alu_result
    );
endinterface

// File: rtl/alu_seq_progmem.sv
// Program store: flop array, synchronous write, asynchronous read, no reset.
module alu_seq_progmem
    import alu_seq_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [PROG_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_sequencer.sv
// Byte-ALU instruction sequencer: issues one op per cycle, resolves branches
// via the ALU status byte. Optional run watchdog: define ALU_SEQ_WATCHDOG_EN.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int  PROG_DEPTH = 16,
    parameter int  WDOG_LIMIT = 255,
    localparam int ADDR_W     = $clog2(PROG_DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               abort,
    output logic [7:0]         result,
    alu_sequencer_if.master    alu
);

    // state        | meaning
    // S_IDLE       | waiting for start, pc parked at 0
    // S_EXEC       | issue the instruction at pc
    // S_ST_WAIT    | status read (0xF) being answered by the ALU
    // S_ST_SAMPLE  | status byte on alu_result, resolve the branch
    // S_DRAIN      | capture accumulator, pulse done

    seq_state_t         state;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    opcode_t            opc;
    logic [OPND_W-1:0]  opnd;
    logic [ADDR_W-1:0]  target;
    logic               branch_taken;
    logic               prog_wr;
    logic               wdog_hit;

    assign prog_wr = prog_we && (state == S_IDLE);
    assign opc     = instr_opcode(instr);
    assign opnd    = instr_operand(instr);
    assign target  = opnd[ADDR_W-1:0];

    alu_seq_progmem #(
        .PROG_DEPTH (PROG_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_progmem (
        .clk   (clk),
        .we    (prog_wr),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (instr)
    );

    // Memory is frozen while busy, so the branch opcode is still at pc here.
    always_comb begin
        branch_taken = 1'b0;
        case (opc)
            OP_JZ:   branch_taken = alu.alu_result[ST_ZERO];
            OP_JN:   branch_taken = alu.alu_result[ST_NEG];
            OP_JC:   branch_taken = alu.alu_result[ST_CARRY];
            default: branch_taken = 1'b0;
        endcase
    end

`ifdef ALU_SEQ_WATCHDOG_EN
    logic [7:0] wdog_cnt;

    assign wdog_hit = (wdog_cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
            abort    <= 1'b0;
        end else if (state == S_IDLE && start) begin
            wdog_cnt <= 8'(WDOG_LIMIT);
            abort    <= 1'b0;
        end else if (state == S_EXEC) begin
            if (wdog_hit) begin
                abort <= 1'b1;
            end else begin
                wdog_cnt <= wdog_cnt - 8'd1;
            end
        end
    end
`else
    logic unused_wdog_limit;

    assign unused_wdog_limit = ^WDOG_LIMIT;
    assign wdog_hit          = 1'b0;
    assign abort             = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pc             <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            result         <= '0;
            alu.alu_opcode <= OP_NOP;
            alu.alu_data   <= '0;
        end else begin
            done           <= 1'b0;
            alu.alu_opcode <= OP_NOP;
            alu.alu_data   <= '0;
            case (state)
                S_IDLE: begin
                    pc <= '0;
                    if (start) begin
                        state <= S_EXEC;
                        busy  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (wdog_hit) begin
                        state <= S_DRAIN;
                    end else begin
                        case (opc)
                            OP_NOP, OP_STATUS: pc <= pc + ADDR_W'(1);
                            OP_JZ, OP_JN, OP_JC: begin
                                alu.alu_opcode <= OP_STATUS;
                                state          <= S_ST_WAIT;
                            end
                            OP_JMP:  pc    <= target;
                            OP_HALT: state <= S_DRAIN;
                            default: begin
                                alu.alu_opcode <= opc;
                                alu.alu_data   <= opnd;
                                pc             <= pc + ADDR_W'(1);
                            end
                        endcase
                    end
                end
                S_ST_WAIT: state <= S_ST_SAMPLE;
                S_ST_SAMPLE: begin
                    pc    <= branch_taken ? target : pc + ADDR_W'(1);
                    state <= S_EXEC;
                end
                S_DRAIN: begin
                    result <= alu.alu_result;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed table, corner sequences and
// random forward-branching programs against an instruction-level model.
`timescale 1ns/1ps
module tb_alu_sequencer;

    localparam int DEPTH = 16;
    localparam int WDOG  = 255;
`ifdef ALU_SEQ_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [11:0] prog_data = '0;
    logic        start = 1'b0;
    logic        busy, done, abort;
    logic [7:0]  result;

    alu_sequencer_if alu();

    alu_sequencer #(.PROG_DEPTH(DEPTH), .WDOG_LIMIT(WDOG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .abort     (abort),
        .result    (result),
        .alu       (alu)
    );

    always #5 clk = ~clk;

    // Byte ALU: flags {carry, neg, zero}; returns {flags, acc}.
    function automatic logic [10:0] alu_apply(input logic [3:0] op, input logic [7:0] d,
                                              input logic [7:0] a, input logic [2:0] f);
        logic [8:0] w;
        logic [7:0] r;
        logic       c;
        r = a;
        c = 1'b0;
        case (op)
            4'h1: r = d;
            4'h2: begin w = {1'b0, a} + {1'b0, d}; r = w[7:0]; c = w[8]; end
            4'h3: begin r = a - d; c = (a < d); end
            4'h4: r = 8'h00;
            4'h5: r = 8'h01;
            4'h6: r = a ^ d;
            4'h7: r = ~a;
            4'h8: begin c = a[7]; r = {a[6:0], 1'b0}; end
            4'h9: begin c = a[0]; r = {1'b0, a[7:1]}; end
            default: return {f, a};
        endcase
        return {c, r[7], (r == 8'h00), r};
    endfunction

    logic [7:0]  acc;
    logic [2:0]  flg;
    logic [10:0] alu_nx;

    always @(posedge clk) begin
        if (!rst_n) begin
            acc            <= 8'h00;
            flg            <= 3'b000;
            alu.alu_result <= 8'h00;
        end else begin
            alu_nx = alu_apply(alu.alu_opcode, alu.alu_data, acc, flg);
            acc <= alu_nx[7:0];
            flg <= alu_nx[10:8];
            alu.alu_result <= (alu.alu_opcode == 4'hF) ? {5'b0, flg} : alu_nx[7:0];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, want);
    endtask

    logic [11:0] prog_buf [DEPTH];
    logic [11:0] exp_q [$];
    logic [11:0] got_q [$];
    logic [11:0] first_q [$];
    logic [7:0]  exp_result;
    bit          exp_abort;

    // Instruction-level interpreter: expands each instruction into the bus
    // words it costs, starting from the bench ALU's current accumulator.
    task automatic model_run(input bit wd_en);
        int          pc, nexec;
        logic [7:0]  a, d;
        logic [2:0]  f;
        logic [3:0]  op;
        logic [10:0] nx;
        bit          take;
        pc = 0; nexec = 0; a = acc; f = flg;
        exp_q.delete();
        exp_abort = 1'b0;
        while (exp_q.size() < 2000) begin
            if (wd_en && nexec == WDOG) begin
                exp_q.push_back(12'h000); exp_q.push_back(12'h000);
                exp_abort = 1'b1;
                break;
            end
            nexec++;
            op = prog_buf[pc][11:8];
            d  = prog_buf[pc][7:0];
            if (op <= 4'h9) begin
                exp_q.push_back({op, (op == 4'h0) ? 8'h00 : d});
                nx = alu_apply(op, d, a, f);
                f = nx[10:8]; a = nx[7:0];
                pc = (pc + 1) % DEPTH;
            end else if (op == 4'hF) begin
                exp_q.push_back(12'h000);
                pc = (pc + 1) % DEPTH;
            end else if (op == 4'hD) begin
                exp_q.push_back(12'h000);
                pc = int'(d) % DEPTH;
            end else if (op == 4'hE) begin
                exp_q.push_back(12'h000); exp_q.push_back(12'h000);
                break;
            end else begin
                exp_q.push_back(12'hF00); exp_q.push_back(12'h000); exp_q.push_back(12'h000);
                take = (op == 4'hA) ? f[0] : (op == 4'hB) ? f[1] : f[2];
                pc = take ? int'(d) % DEPTH : (pc + 1) % DEPTH;
            end
        end
        exp_result = a;
    endtask

    task automatic load_prog();
        for (int i = 1; i < DEPTH; i++) begin
            @(negedge clk);
            prog_we = 1'b1; prog_addr = 4'(i); prog_data = prog_buf[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Starts a run (optionally writing addr 0 in the start cycle) and records
    // the bus word after every edge until done or the budget runs out.
    task automatic do_run(input bit wr0, input int inject_at, input int budget,
                          output int lat, output bit tmo);
        got_q.delete();
        lat = 0; tmo = 1'b1;
        @(negedge clk);
        prog_we = wr0; prog_addr = 4'h0; prog_data = prog_buf[0]; start = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        check("busy_rise", busy, 1);
        for (int c = 1; c <= budget; c++) begin
            if (c == inject_at) begin
                start = 1'b1; prog_we = 1'b1; prog_addr = 4'h0; prog_data = 12'h1AA;
            end
            @(negedge clk);
            start = 1'b0; prog_we = 1'b0;
            got_q.push_back({alu.alu_opcode, alu.alu_data});
            if (done) begin lat = c; tmo = 1'b0; break; end
        end
    endtask

    task automatic run_checks(input string nm, input int lat, input bit tmo);
        int diff;
        check({nm, " timeout"}, tmo, 0);
        check({nm, " latency"}, lat, exp_q.size());
        diff = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (diff < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) diff = i;
        if (diff < 0 && got_q.size() != exp_q.size()) diff = exp_q.size();
        n_checks++;
        if (diff < 0) n_pass++;
        else $display("FAIL %s trace: first diff at %0d got %03h expected %03h (got len %0d, expected len %0d)",
                      nm, diff, (diff < got_q.size()) ? got_q[diff] : 12'hfff,
                      (diff < exp_q.size()) ? exp_q[diff] : 12'hfff, got_q.size(), exp_q.size());
        check({nm, " result"}, result, exp_result);
        check({nm, " busy_at_done"}, busy, 0);
        check({nm, " abort"}, abort, exp_abort);
        @(negedge clk);
        check({nm, " done_pulse"}, done, 0);
        check({nm, " result_held"}, result, exp_result);
    endtask

    typedef struct packed {
        logic [0:4][11:0] head;
        logic [7:0]       want_result;
        int               want_lat;
        int               want_f;
        logic [11:0]      cnt_word;
        int               want_cnt;
        logic [0:2][3:0]  want_ops;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int          lat, fcnt, wcnt, busy_cnt;
        bit          tmo, found, saw_done, same;
        int          k;
        logic [3:0]  op;
        logic [7:0]  d;
        logic [11:0] ops3;

        vecs[0] = '{{12'h105, 12'h203, 12'hE00, 12'hE00, 12'hE00}, 8'h08, 4, 0, 12'h203, 1, {4'h1, 4'h2, 4'h0}};
        vecs[1] = '{{12'h103, 12'h301, 12'hA04, 12'hD01, 12'hE00}, 8'h00, 17, 3, 12'h301, 3, {4'h1, 4'h3, 4'hF}};
        vecs[2] = '{{12'h1FF, 12'h201, 12'hC04, 12'h155, 12'hE00}, 8'h00, 7, 1, 12'h155, 0, {4'h1, 4'h2, 4'hF}};

        repeat (3) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst abort", abort, 0);
        check("rst result", result, 8'h00);
        check("rst opcode", alu.alu_opcode, 4'h0);
        check("rst data", alu.alu_data, 8'h00);
        rst_n = 1'b1;

        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < DEPTH; i++) prog_buf[i] = (i < 5) ? vecs[v].head[i] : 12'hE00;
            load_prog();
            model_run(WD_EN);
            do_run(1'b1, -1, 200, lat, tmo);
            fcnt = 0; wcnt = 0;
            foreach (got_q[i]) begin
                if (got_q[i][11:8] == 4'hF) fcnt++;
                if (got_q[i] == vecs[v].cnt_word) wcnt++;
            end
            ops3 = (got_q.size() >= 3) ? {got_q[0][11:8], got_q[1][11:8], got_q[2][11:8]} : 12'hfff;
            check($sformatf("vec%0d lat_table", v), lat, vecs[v].want_lat);
            check($sformatf("vec%0d result_table", v), result, vecs[v].want_result);
            check($sformatf("vec%0d status_reads", v), fcnt, vecs[v].want_f);
            check($sformatf("vec%0d word_count", v), wcnt, vecs[v].want_cnt);
            check($sformatf("vec%0d first_ops", v), ops3, vecs[v].want_ops);
            run_checks($sformatf("vec%0d", v), lat, tmo);
        end

        // start + prog_we while busy are ignored; rerun gives the same trace
        for (int i = 0; i < DEPTH; i++) prog_buf[i] = (i < 5) ? vecs[0].head[i] : 12'hE00;
        load_prog();
        model_run(WD_EN);
        do_run(1'b1, 2, 200, lat, tmo);
        run_checks("busy_ignore", lat, tmo);
        first_q = got_q;
        model_run(WD_EN);
        do_run(1'b0, -1, 200, lat, tmo);
        run_checks("rerun", lat, tmo);
        same = (first_q.size() == got_q.size());
        foreach (first_q[i]) if (i < got_q.size() && first_q[i] !== got_q[i]) same = 1'b0;
        check("rerun identical", same, 1);
        check("rerun result", result, 8'h08);

        // reset while the status read is in flight
        for (int i = 0; i < DEPTH; i++) prog_buf[i] = (i < 5) ? vecs[1].head[i] : 12'hE00;
        load_prog();
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'h0; prog_data = prog_buf[0]; start = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (alu.alu_opcode == 4'hF) begin found = 1'b1; break; end
        end
        check("midrun reached status read", found, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrun rst busy", busy, 0);
        check("midrun rst opcode", alu.alu_opcode, 4'h0);
        check("midrun rst result", result, 8'h00);
        check("midrun rst done", done, 0);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (30) begin @(negedge clk); if (done || busy) saw_done = 1'b1; end
        check("midrun no done after rst", saw_done, 0);

        // random forward-branching programs always reach HALT
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                k = $urandom_range(0, 9);
                d = 8'($urandom);
                if (k <= 5) op = 4'($urandom_range(0, 9));
                else if (k == 6) op = 4'hF;
                else if (k <= 8) begin
                    op = 4'($urandom_range(10, 13));
                    d = {d[7:4], 4'($urandom_range(i + 1, DEPTH - 1))};
                end else op = 4'hE;
                prog_buf[i] = {op, d};
            end
            prog_buf[DEPTH-1] = {4'hE, 8'($urandom)};
            load_prog();
            model_run(WD_EN);
            do_run(1'b1, -1, 300, lat, tmo);
            run_checks($sformatf("rand%0d", r), lat, tmo);
        end

        // program with no HALT: {0: JMP 0}
        prog_buf[0] = 12'hD00;
        for (int i = 1; i < DEPTH; i++) prog_buf[i] = 12'hE00;
        load_prog();
`ifdef ALU_SEQ_WATCHDOG_EN
        model_run(1'b1);
        do_run(1'b1, -1, 400, lat, tmo);
        check("wdog latency", lat, 257);
        check("wdog abort at done", abort, 1);
        run_checks("wdog", lat, tmo);
        check("wdog abort held", abort, 1);
        for (int i = 0; i < DEPTH; i++) prog_buf[i] = (i < 5) ? vecs[0].head[i] : 12'hE00;
        load_prog();
        model_run(1'b1);
        do_run(1'b1, -1, 200, lat, tmo);
        run_checks("after_wdog", lat, tmo);
`else
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'h0; prog_data = prog_buf[0]; start = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        busy_cnt = 0; saw_done = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) saw_done = 1'b1;
        end
        check("nohalt busy cycles", busy_cnt, 1000);
        check("nohalt no done", saw_done, 0);
        check("nohalt abort", abort, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("nohalt rst busy", busy, 0);
        rst_n = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: bench did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
